// File: rtl/regfile_wb.sv
// 32x32 register file with a one-deep write-back staging register.
// Reads forward the incoming write and then the staged write ahead of the array.
module regfile_wb_entry (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic [31:0] en,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            q <= '0;
        end else begin
            for (int b = 0; b < 32; b++)
                if (en[b]) q[b] <= d[b];
        end
    end
endmodule

module regfile_wb (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic        pend_valid_o
);
    logic        pend_valid;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;
    logic [31:0] arr [32];

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else if (wr_en_i && (wr_addr_i != 5'd0)) begin
            pend_valid <= 1'b1;
            pend_addr  <= wr_addr_i;
            pend_data  <= wr_data_i;
        end else begin
            pend_valid <= 1'b0;
        end
    end

    // x0 has no storage; entries x1..x31 commit whole-word from the staging register
    assign arr[0] = '0;
    for (genvar i = 1; i < 32; i++) begin : g_ent
        logic [31:0] en;
        assign en = (pend_valid && (pend_addr == 5'(i))) ? '1 : '0;
        regfile_wb_entry u_ent (
            .clk_i  (clk_i),
            .nrst_i (nrst_i),
            .en     (en),
            .d      (pend_data),
            .q      (arr[i])
        );
    end

    function automatic logic [31:0] rd(input logic [4:0] a, input logic [31:0] mem);
        logic [31:0] r;
        r = mem;
        if (a == 5'd0)                           r = '0;
        else if (wr_en_i && (wr_addr_i == a))    r = wr_data_i;
        else if (pend_valid && (pend_addr == a)) r = pend_data;
        return r;
    endfunction

    always_comb begin
        rs1_data_o = rd(rs1_addr_i, arr[rs1_addr_i]);
        rs2_data_o = rd(rs2_addr_i, arr[rs2_addr_i]);
    end

    assign pend_valid_o = pend_valid;
endmodule
